// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer: 1-bit-per-cycle shift-add multiply and restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module muldiv_seq #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req_valid,
  input  logic [5:0]   req_func,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] rd_data,
  output logic [1:0]   dbg_state,
  output logic [W-1:0] dbg_hi,
  output logic [W-1:0] dbg_lo
);

  localparam int CW = $clog2(W);
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    hi, lo, p, q, mcand, a_orig;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, op_div, b_zero;

  // Handshake: a supported request is taken at the edge where req_valid=1 and stall=0
  // (and flush=0); while stall is high the requester holds func/operands stable.
  logic            f_muldiv, f_move, req_div, req_signed, accept, mt_write;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  assign f_muldiv   = (req_func == F_MULT) || (req_func == F_MULTU) ||
                      (req_func == F_DIV)  || (req_func == F_DIVU);
  assign f_move     = (req_func == F_MFHI) || (req_func == F_MTHI) ||
                      (req_func == F_MFLO) || (req_func == F_MTLO);
  assign req_div    = (req_func == F_DIV) || (req_func == F_DIVU);
  assign req_signed = (req_func == F_MULT) || (req_func == F_DIV);
  assign accept     = (state == S_IDLE) && req_valid && f_muldiv && !flush;
  assign mt_write   = (state == S_IDLE) && req_valid && !flush &&
                      ((req_func == F_MTHI) || (req_func == F_MTLO));
  assign a_neg      = req_signed && req_a[W-1];
  assign b_neg      = req_signed && req_b[W-1];
  assign a_mag      = a_neg ? -req_a : req_a;
  assign b_mag      = b_neg ? -req_b : req_b;

  // One multiply step: conditional add into the upper half, then shift {carry,P,Q} right.
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_ext, mul_next;
  logic            mul_last;
  assign mul_sum = {1'b0, p} + (q[0] ? {1'b0, mcand} : {(W+1){1'b0}});
  assign mul_ext = {mul_sum, q[W-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
  // q[cnt:1] are the multiplier bits still to be consumed after this step.
  logic [W-1:0] rest_mask;
  assign rest_mask = ({W{1'b1}} >> (CW'(W-1) - cnt)) & ~W'(1);
  assign mul_last  = (cnt == '0) || ((q & rest_mask) == '0);
  assign mul_next  = mul_last ? (mul_ext >> cnt) : mul_ext;
`else
  assign mul_last  = (cnt == '0);
  assign mul_next  = mul_ext;
`endif

  logic [W:0]      rem_sh, div_diff;
  logic            div_ok;
  assign rem_sh   = {p, q[W-1]};
  assign div_diff = rem_sh - {1'b0, mcand};
  assign div_ok   = ~div_diff[W];

  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;
  assign prod_fix = neg_q ? -{p, q} : {p, q};
  assign quot_fix = neg_q ? -q : q;
  assign rem_fix  = neg_r ? -p : p;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = req_div ? S_DIV : S_MUL;
      S_MUL:  if (flush) state_nxt = S_IDLE; else if (mul_last) state_nxt = S_FIX;
      S_DIV:  if (flush) state_nxt = S_IDLE; else if (cnt == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    stall     = req_valid && (f_muldiv || f_move) && (state != S_IDLE);
    rd_data   = '0;
    if (req_valid && req_func == F_MFHI) rd_data = hi;
    if (req_valid && req_func == F_MFLO) rd_data = lo;
    dbg_state = state;
    dbg_hi    = hi;
    dbg_lo    = lo;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi <= '0; lo <= '0; p <= '0; q <= '0; mcand <= '0; a_orig <= '0;
      cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0; op_div <= 1'b0; b_zero <= 1'b0;
      div0 <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            p      <= '0;
            q      <= req_div ? a_mag : b_mag;
            mcand  <= req_div ? b_mag : a_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            op_div <= req_div;
            b_zero <= (req_b == '0);
            a_orig <= req_a;
            cnt    <= CW'(W-1);
            if (req_div && req_b != '0) div0 <= 1'b0;
          end else if (mt_write) begin
            if (req_func == F_MTHI) hi <= req_a;
            else                    lo <= req_a;
          end
        end
        S_MUL: if (!flush) begin
          {p, q} <= mul_next;
          cnt    <= cnt - 1'b1;
        end
        S_DIV: if (!flush) begin
          p   <= div_ok ? div_diff[W-1:0] : rem_sh[W-1:0];
          q   <= {q[W-2:0], div_ok};
          cnt <= cnt - 1'b1;
        end
        S_FIX: if (!flush) begin
          done <= 1'b1;
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            lo   <= '1;
            hi   <= a_orig;
            div0 <= 1'b1;
          end else begin
            lo <= quot_fix;
            hi <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random HI/LO traffic against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_BAD   = 6'h20;

  logic         CLK, RST_N, req_valid, flush;
  logic [5:0]   req_func;
  logic [W-1:0] req_a, req_b;
  logic         stall, busy, done, div0;
  logic [W-1:0] rd_data, dbg_hi, dbg_lo;
  logic [1:0]   dbg_state;

  muldiv_seq #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_func(req_func),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .div0(div0), .rd_data(rd_data), .dbg_state(dbg_state),
    .dbg_hi(dbg_hi), .dbg_lo(dbg_lo)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  // entry: {busy_len[7:0], div0, hi[31:0], lo[31:0]}
  logic [72:0] exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic m_div0 = 1'b0;
  int last_blen = 0;
  int last_stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on the architectural HI/LO pair
  task automatic model_apply(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] prod;
    logic [W-1:0] mag;
    int blen;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    blen = W + 1;
    mag = b;
    case (f)
      F_MULT, F_MULTU: begin
        if (f == F_MULT) prod = sa * sb;
        else             prod = {32'b0, a} * {32'b0, b};
        m_hi = prod[63:32];
        m_lo = prod[31:0];
`ifdef MULDIV_EARLY_OUT_EN
        if (f == F_MULT && b[31]) mag = -b;
        blen = 2;
        for (int i = 0; i < W; i++) if (mag[i]) blen = i + 2;
`endif
      end
      F_DIV, F_DIVU: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
          m_div0 = 1'b1;
        end else begin
          m_div0 = 1'b0;
          if (f == F_DIVU) begin
            m_lo = a / b;
            m_hi = a % b;
          end else begin
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
          end
        end
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
    if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) begin
      exp_q.push_back({8'(blen), m_div0, m_hi, m_lo});
      last_blen = blen;
    end
  endtask

  // monitor / scoreboard
  int busy_cnt = 0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      busy_cnt <= 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        check("hi", 64'(dbg_hi), 64'(exp_q[0][63:32]));
        check("lo", 64'(dbg_lo), 64'(exp_q[0][31:0]));
        check("div0", 64'(div0), 64'(exp_q[0][64]));
        check("busy_len", 64'(busy_cnt), 64'(exp_q[0][72:65]));
        void'(exp_q.pop_front());
      end
      busy_cnt <= 0;
    end else if (busy) begin
      busy_cnt <= busy_cnt + 1;
    end else begin
      busy_cnt <= 0;
    end
  end

  // driver tasks (entered #1 after a rising edge)
  task automatic op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
    @(negedge CLK);
    while (stall && n < 200) begin
      n++;
      @(negedge CLK);
    end
    last_stalls = n;
    if (stall) check("stall_timeout", 64'(stall), 64'd0);
    if (f == F_MFHI) check("mfhi_rd", 64'(rd_data), 64'(m_hi));
    if (f == F_MFLO) check("mflo_rd", 64'(rd_data), 64'(m_lo));
    model_apply(f, a, b);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_func = 6'h00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      n++;
      @(posedge CLK); #1;
    end
    if (n >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // start an operation that will be aborted, so nothing is expected from it
  task automatic raw_start(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
    @(negedge CLK);
    check("raw_accept_stall", 64'(stall), 64'd0);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_func = 6'h00;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  logic [5:0] funcs [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};

  initial begin
    RST_N = 1'b1; req_valid = 1'b0; req_func = 6'h00; req_a = '0; req_b = '0; flush = 1'b0;
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_hi", 64'(dbg_hi), 64'd0);
    check("rst_lo", 64'(dbg_lo), 64'd0);
    req_valid = 1'b1; req_func = F_MFLO;
    #1 check("rst_rd_lo", 64'(rd_data), 64'd0);
    req_valid = 1'b0; req_func = 6'h00;
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;

    // multiply, then MFHI stalled until the result lands
    op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    op(F_MFHI, '0, '0);
    check("mfhi_stall_len", 64'(last_stalls), 64'(last_blen));
    op(F_MFLO, '0, '0);
    op(F_MULTU, 32'hFFFF_FFFD, 32'd7);
    op(F_DIVU, 32'd100, 32'd7);
    op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    op(F_DIV, 32'd55, 32'd0);
    op(F_DIVU, 32'd9, 32'd3);

    // MTLO while busy waits for the multiply, then overwrites LO
    op(F_MULT, 32'd5, 32'd6);
    op(F_MTLO, 32'h0000_CAFE, '0);
    check("mtlo_stall_len", 64'(last_stalls), 64'(last_blen));
    op(F_MFLO, '0, '0);
    op(F_MULTU, 32'h0000_1234, 32'd3);

    // unsupported func never stalls
    op(F_MULTU, W'($urandom()), W'($urandom()));
    req_valid = 1'b1; req_func = F_BAD;
    @(negedge CLK);
    check("bad_func_stall", 64'(stall), 64'd0);
    check("bad_func_busy", 64'(busy), 64'd1);
    req_valid = 1'b0; req_func = 6'h00;
    drain();
    req_valid = 1'b1; req_func = F_BAD;
    #1 check("bad_func_rd", 64'(rd_data), 64'd0);
    req_valid = 1'b0; req_func = 6'h00;

    // flush mid-multiply and in the FIX cycle
    op(F_MTHI, 32'h11, '0);
    op(F_MTLO, 32'h22, '0);
    raw_start(F_MULTU, W'($urandom()) | 32'h1, W'($urandom()) | 32'h8000_0000);
    repeat (4) @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    check("flush_mul_busy", 64'(busy), 64'd0);
    check("flush_mul_done", 64'(done), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    op(F_MFHI, '0, '0);
    op(F_MFLO, '0, '0);
    raw_start(F_DIV, W'($urandom()), 32'd3);
    repeat (W) @(posedge CLK);
    #1 check("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    check("flush_fix_busy", 64'(busy), 64'd0);
    check("flush_fix_hi", 64'(dbg_hi), 64'h11);
    check("flush_fix_lo", 64'(dbg_lo), 64'h22);
    check("flush_fix_done", 64'(done), 64'd0);

    // flush in IDLE blocks MTHI and MULT
    flush = 1'b1; req_valid = 1'b1; req_func = F_MTHI; req_a = 32'hDEAD;
    @(posedge CLK); #1;
    check("flush_idle_mthi", 64'(dbg_hi), 64'h11);
    req_func = F_MULT; req_a = 32'd3; req_b = 32'd4;
    @(posedge CLK); #1;
    check("flush_idle_mult", 64'(busy), 64'd0);
    flush = 1'b0; req_valid = 1'b0; req_func = 6'h00;

    // async reset mid-multiply clears everything including sticky div0
    op(F_DIV, 32'd55, 32'd0);
    drain();
    raw_start(F_MULT, W'($urandom()) | 32'h1, 32'hFFFF_FFFF);
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("amid_rst_busy", 64'(busy), 64'd0);
    check("amid_rst_done", 64'(done), 64'd0);
    check("amid_rst_hi", 64'(dbg_hi), 64'd0);
    check("amid_rst_lo", 64'(dbg_lo), 64'd0);
    check("amid_rst_div0", 64'(div0), 64'd0);
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_done", 64'(done), 64'd0);

    // random traffic, including back-to-back issue in the done cycle
    repeat (40) begin
      op(funcs[$urandom_range(0, 7)], pick(), pick());
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    drain();
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Replaces single-cycle MULT/DIV in EX with a 1-bit-per-cycle engine: shift-add multiply, restoring divide.
- Sits beside EX. EX presents R-format HI/LO-related requests.
- Block returns HI/LO for MFHI/MFLO and raises a stall to the pipeline controller while a result is pending.

Parameters:
- W, 32, operand/HI/LO width; must be even and >= 4. Iteration count = W.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds an R-format instruction whose func is in the supported set
- req_func  in  6  func field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- req_a  in  W  rs value (Rdata1)
- req_b  in  W  rt value (Rdata2)
- flush  in  1  abort in-flight operation (branch/exception kill)
- stall  out  1  pipeline must hold EX this cycle
- busy  out  1  engine iterating
- done  out  1  one-cycle pulse; new HI/LO visible this cycle
- div0  out  1  sticky; last DIV/DIVU had a zero divisor
- rd_data  out  W  HI for MFHI, LO for MFLO; 0 otherwise

Behaviour:
- Reset (RST_N low, async): state IDLE, HI=LO=0, counter=0, busy=0, done=0, div0=0. rd_data follows HI/LO=0.
- States: IDLE, MUL, DIV, FIX.
- Accept: occurs at the edge where state=IDLE, req_valid=1, func in {MULT,MULTU,DIV,DIVU}, flush=0.
  - Latch operands.
  - Signed ops: latch magnitudes plus sign flags (neg_q = sa^sb, neg_r = sa).
  - Counter = W-1. Go to MUL or DIV.
- MUL: each cycle, if multiplier LSB then add multiplicand into upper partial product; shift {P,multiplier} right 1. At counter=0 go to FIX; otherwise decrement.
- DIV: restoring divide, remainder shift-left with the next dividend bit, subtract if no borrow, shift quotient bit in. At counter=0 go to FIX.
- FIX (1 cycle):
  - Apply sign correction with two's complement at W or 2W width as needed.
  - Write HI/LO: MULT → {HI,LO} = 2W product. DIV → LO = quotient, HI = remainder (remainder takes dividend sign).
  - Next state IDLE. done=1 in the cycle after FIX, when HI/LO show the new value.
- Latency: busy=1 for W+1 cycles after the accept edge. Result is readable W+2 cycles after accept.
- Divide by zero:
  - Still runs all W iterations; no early exit.
  - FIX writes LO = all-ones, HI = dividend (signed: original signed dividend). div0 set.
  - div0 clears on the next accepted DIV/DIVU with a nonzero divisor.
- DIV of -2^(W-1) by -1: LO = 0x80000000, HI = 0. No trap.
- MTHI/MTLO: in IDLE with req_valid, write HI or LO from req_a at the edge. Single cycle, no stall.
- MFHI/MFLO: rd_data is combinational from the current HI/LO.
- stall = req_valid & func in supported set & (state != IDLE). While stalled, nothing is accepted and requests must hold stable.
- Back-to-back: a request presented in the done cycle is accepted; state is IDLE. MFHI in the done cycle returns the new HI.
- flush:
  - In MUL/DIV/FIX: go to IDLE next edge. HI/LO, div0 unchanged. No done.
  - In IDLE: blocks acceptance of that cycle's request, including MTHI/MTLO.
  - flush wins over FIX write.
- Unsupported func with req_valid: ignored, no stall.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX after aligning the partial product (one combined shift by counter+1). Zero or small multipliers finish early. busy length = (index of highest set multiplier bit) + 2 cycles, minimum 2.
- Undefined: fixed W+1 busy cycles for every operation. DIV is unaffected in both builds.

Test Plan:
- Reset mid-MUL: assert RST_N low at iteration 10 → HI=LO=0, busy=0 immediately (async); no done.
- MULT a=0xFFFFFFFD (-3), b=7 → done after 33 busy cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 55/0 → LO=0xFFFFFFFF, HI=55, div0=1. Following DIVU 9/3 → LO=3, HI=0, div0=0.
- MFHI issued 1 cycle after MULT accept → stall high for 33 cycles, then rd_data = new HI in the done cycle. MTLO while busy stalls and writes LO only after FIX.
- flush at MUL iteration 5 after prior HI=0x11, LO=0x22 → IDLE next edge, HI/LO remain 0x11/0x22, no done. With MULDIV_EARLY_OUT_EN, MULTU 0x1234×3 → busy 3 cycles, LO=0x369C.
